fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV64 core. It sits directly upstream of decode.
- Owns the architectural PC and drives the combinational instruction-memory address.
- Captures the returned instruction with its PC and PC+4 into the IF/ID register.
- Supports decode stalls and branch/jump redirects from EX, which squash the wrong-path instruction.
- Keeps a sticky misaligned-redirect flag and a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the pipelined
//   RV64 core. Owns the architectural PC, presents it combinationally to the
//   instruction memory and latches the returned instruction together with its
//   PC and PC+4. Decode stalls freeze the stage; EX redirects reload the PC and
//   squash the wrong-path instruction by inserting a bubble into IF/ID.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-high reset
//   stall            in   decode hazard, hold PC / IF/ID / counter
//   redirect_valid   in   taken branch/jump resolved in EX this cycle
//   redirect_target  in   new fetch PC (low two bits forced to zero)
//   imem_addr        out  instruction memory address (= PC register)
//   imem_data        in   instruction memory read data, same cycle
//   if_id_pc         out  PC of the instruction held in IF/ID
//   if_id_pc_plus4   out  if_id_pc + 4
//   if_id_instr      out  instruction held in IF/ID (NOP_INSTR for a bubble)
//   if_id_valid      out  IF/ID holds a real instruction
//   misaligned       out  sticky: some redirect target had bits[1:0] != 0
//   fetch_count      out  number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          PC_WIDTH    = 64,
  parameter int          INSTR_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic                   misaligned,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  localparam logic [PC_WIDTH-1:0]    PC_STEP   = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0]    PC_INIT   = RESET_PC[PC_WIDTH-1:0];
  localparam logic [INSTR_WIDTH-1:0] NOP_VALUE = NOP_INSTR[INSTR_WIDTH-1:0];

  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_ifIdPc;
  logic [PC_WIDTH-1:0]    r_ifIdPcPlus4;
  logic [INSTR_WIDTH-1:0] r_ifIdInstr;
  logic                   r_ifIdValid;
  logic                   r_misaligned;
  logic [CNT_WIDTH-1:0]   r_fetchCount;

  logic [PC_WIDTH-1:0]    w_pcPlus4;
  logic [PC_WIDTH-1:0]    w_redirectPc;
  logic                   w_targetMisaligned;

  // Sequential PC increment wraps naturally modulo 2^PC_WIDTH. Redirect
  // targets are word-aligned by clearing the low two bits; those bits are
  // kept only to raise the sticky misaligned flag.
  always_comb begin
    w_pcPlus4          = r_pc + PC_STEP;
    w_redirectPc       = {redirect_target[PC_WIDTH-1:2], 2'b00};
    w_targetMisaligned = |redirect_target[1:0];
  end

  // PC register. Redirect wins over stall, stall wins over sequential fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= PC_INIT;
    end else if (redirect_valid) begin
      r_pc <= w_redirectPc;
    end else if (!stall) begin
      r_pc <= w_pcPlus4;
    end
  end

  // IF/ID register and fetch counter. A redirect squashes the instruction
  // fetched this cycle (it came from the wrong path) by loading a bubble; the
  // PC fields are left alone because a bubble carries no meaningful PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ifIdPc      <= '0;
      r_ifIdPcPlus4 <= '0;
      r_ifIdInstr   <= NOP_VALUE;
      r_ifIdValid   <= 1'b0;
      r_fetchCount  <= '0;
    end else if (redirect_valid) begin
      r_ifIdInstr <= NOP_VALUE;
      r_ifIdValid <= 1'b0;
    end else if (!stall) begin
      r_ifIdPc      <= r_pc;
      r_ifIdPcPlus4 <= w_pcPlus4;
      r_ifIdInstr   <= imem_data;
      r_ifIdValid   <= 1'b1;
      r_fetchCount  <= r_fetchCount + 1'b1;
    end
  end

  // Sticky debug flag: once any redirect asks for a non-word-aligned target it
  // stays set until the next reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else if (redirect_valid && w_targetMisaligned) begin
      r_misaligned <= 1'b1;
    end
  end

  // All outputs come straight from registers, so stall and redirect have no
  // combinational path to any output.
  always_comb begin
    imem_addr      = r_pc;
    if_id_pc       = r_ifIdPc;
    if_id_pc_plus4 = r_ifIdPcPlus4;
    if_id_instr    = r_ifIdInstr;
    if_id_valid    = r_ifIdValid;
    misaligned     = r_misaligned;
    fetch_count    = r_fetchCount;
  end

endmodule
